// File: rtl/rom_socket_reader.sv
`default_nettype none
// ============================================================================
// Module      : rom_socket_reader
// Description : Initiator for an asynchronous ROM socket. Turns a one-cycle
//               read request (optionally a sequential burst) into chip/output
//               enable sequencing and returns each byte as a response pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_socket_reader #(
    parameter int ADDR_WIDTH      = 13,
    parameter int DATA_WIDTH      = 8,
    parameter int ACCESS_CYCLES   = 2,
    parameter int RECOVERY_CYCLES = 1
) (
    input  logic                  clk_core,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [7:0]            req_count,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_last,
    output logic                  busy,
    output logic                  rom_ce_n,
    output logic                  rom_oe_n,
    output logic [ADDR_WIDTH-1:0] rom_a,
    input  logic [DATA_WIDTH-1:0] rom_d
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_ACCESS  = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    // Counters run from N-1 down to 0, so the reload values are N-1.
    localparam logic [3:0] c_ACCESS_RELOAD  = 4'(ACCESS_CYCLES - 1);
    localparam logic [3:0] c_RECOVER_RELOAD = 4'(RECOVERY_CYCLES - 1);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic [7:0] r_remaining;
    logic       w_accept;

    // req_ready is a registered copy of (state == IDLE), so it gates acceptance.
    assign w_accept = req_valid && req_ready;

    // Socket sequencer: every output is a register updated on state transitions.
    always_ff @(posedge clk_core) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_remaining <= 8'd0;
            req_ready   <= 1'b1;
            busy        <= 1'b0;
            rom_ce_n    <= 1'b1;
            rom_oe_n    <= 1'b1;
            rom_a       <= '0;
            rsp_valid   <= 1'b0;
            rsp_last    <= 1'b0;
            rsp_data    <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state     <= ST_SETUP;
                        req_ready   <= 1'b0;
                        busy        <= 1'b1;
                        rom_ce_n    <= 1'b0;
                        rom_a       <= req_addr;
                        r_remaining <= req_count;
                    end
                end
                ST_SETUP: begin
                    // Address and chip enable have had one cycle to settle.
                    r_state  <= ST_ACCESS;
                    rom_oe_n <= 1'b0;
                    r_cnt    <= c_ACCESS_RELOAD;
                end
                ST_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        rsp_data  <= rom_d;
                        rsp_valid <= 1'b1;
                        rsp_last  <= (r_remaining == 8'd0);
                        if (r_remaining != 8'd0) begin
                            // Next byte: enables stay low, address steps on the boundary.
                            r_remaining <= r_remaining - 8'd1;
                            rom_a       <= rom_a + 1'b1;
                            r_cnt       <= c_ACCESS_RELOAD;
                        end else begin
                            r_state  <= ST_RECOVER;
                            rom_ce_n <= 1'b1;
                            rom_oe_n <= 1'b1;
                            r_cnt    <= c_RECOVER_RELOAD;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RECOVER: begin
                    if (r_cnt == 4'd0) begin
                        r_state   <= ST_IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    rom_ce_n  <= 1'b1;
                    rom_oe_n  <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rom_socket_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_socket_reader
// Description : Scoreboard bench for rom_socket_reader. Instance A uses the
//               default timing with a registered ROM model; instance B uses
//               ACCESS_CYCLES=1 with a combinational ROM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_socket_reader;

    localparam int AW = 13;
    localparam int DW = 8;

    typedef struct {
        int cyc;
        int data;
        bit last;
    } rsp_t;

    typedef struct {
        int cyc;
        bit ce;
        bit oe;
        bit rdy;
        bit busy;
        bit chk_a;
        int a;
    } ctl_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic          a_req_valid, a_req_ready, a_rsp_valid, a_rsp_last, a_busy, a_ce_n, a_oe_n;
    logic [AW-1:0] a_req_addr, a_rom_a;
    logic [7:0]    a_req_count;
    logic [DW-1:0] a_rsp_data, a_rom_d;

    logic          b_req_valid, b_req_ready, b_rsp_valid, b_rsp_last, b_busy, b_ce_n, b_oe_n;
    logic [AW-1:0] b_req_addr, b_rom_a;
    logic [7:0]    b_req_count;
    logic [DW-1:0] b_rsp_data, b_rom_d;

    rom_socket_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACCESS_CYCLES(2), .RECOVERY_CYCLES(1)) u_dut_a (
        .clk_core(clk), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr), .req_count(a_req_count),
        .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data), .rsp_last(a_rsp_last), .busy(a_busy),
        .rom_ce_n(a_ce_n), .rom_oe_n(a_oe_n), .rom_a(a_rom_a), .rom_d(a_rom_d)
    );

    rom_socket_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACCESS_CYCLES(1), .RECOVERY_CYCLES(1)) u_dut_b (
        .clk_core(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr), .req_count(b_req_count),
        .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .rsp_last(b_rsp_last), .busy(b_busy),
        .rom_ce_n(b_ce_n), .rom_oe_n(b_oe_n), .rom_a(b_rom_a), .rom_d(b_rom_d)
    );

    // ROM contents: each location holds the low byte of its address.
    always @(posedge clk) a_rom_d <= a_rom_a[7:0];
    assign b_rom_d = b_rom_a[7:0];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    rsp_t rq_a[$];
    rsp_t rq_b[$];
    ctl_t cq_a[$];
    ctl_t cq_b[$];

    int n_chk  = 0;
    int n_pass = 0;
    bit fin_req  = 1'b0;
    bit fin_done = 1'b0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    endtask

    // Monitor: pops expectations when the DUT presents a response or when a
    // control snapshot falls due.
    always @(negedge clk) begin
        rsp_t r;
        ctl_t c;
        if (a_rsp_valid) begin
            cmp("a_rsp_expected", 32'(rq_a.size() > 0), 32'd1);
            if (rq_a.size() > 0) begin
                r = rq_a.pop_front();
                cmp("a_rsp_cycle", cyc, r.cyc);
                cmp("a_rsp_data", a_rsp_data, r.data);
                cmp("a_rsp_last", a_rsp_last, r.last);
            end
        end
        if (b_rsp_valid) begin
            cmp("b_rsp_expected", 32'(rq_b.size() > 0), 32'd1);
            if (rq_b.size() > 0) begin
                r = rq_b.pop_front();
                cmp("b_rsp_cycle", cyc, r.cyc);
                cmp("b_rsp_data", b_rsp_data, r.data);
                cmp("b_rsp_last", b_rsp_last, r.last);
            end
        end
        while (cq_a.size() > 0 && cq_a[0].cyc <= cyc) begin
            c = cq_a.pop_front();
            cmp("a_ce_n", a_ce_n, c.ce);
            cmp("a_oe_n", a_oe_n, c.oe);
            cmp("a_req_ready", a_req_ready, c.rdy);
            cmp("a_busy", a_busy, c.busy);
            if (c.chk_a) cmp("a_rom_a", a_rom_a, c.a);
        end
        while (cq_b.size() > 0 && cq_b[0].cyc <= cyc) begin
            c = cq_b.pop_front();
            cmp("b_ce_n", b_ce_n, c.ce);
            cmp("b_oe_n", b_oe_n, c.oe);
            cmp("b_req_ready", b_req_ready, c.rdy);
            cmp("b_busy", b_busy, c.busy);
            if (c.chk_a) cmp("b_rom_a", b_rom_a, c.a);
        end
        if (fin_req && !fin_done) begin
            cmp("a_rsp_missing", rq_a.size(), 0);
            cmp("b_rsp_missing", rq_b.size(), 0);
            cmp("a_ctl_pending", cq_a.size(), 0);
            cmp("b_ctl_pending", cq_b.size(), 0);
            fin_done = 1'b1;
        end
    end

    task automatic push_ctl(input bit b, input int c, input bit ce, input bit oe,
                            input bit rdy, input bit bsy, input bit chk_a, input int a);
        ctl_t e;
        e.cyc = c; e.ce = ce; e.oe = oe; e.rdy = rdy; e.busy = bsy; e.chk_a = chk_a; e.a = a;
        if (b) cq_b.push_back(e);
        else   cq_a.push_back(e);
    endtask

    // Expected timeline of a transaction accepted in cycle t; nothing after cycle cut.
    task automatic push_txn(input bit b, input int t, input int addr, input int cnt,
                            input int ac, input int cut);
        int   n;
        int   endc;
        rsp_t r;
        n    = cnt + 1;
        endc = t + 2 + ac * n;
        for (int k = 0; k < n; k++) begin
            r.cyc  = t + 2 + ac * (k + 1);
            r.data = (addr + k) & 'hFF;
            r.last = (k == n - 1);
            if (r.cyc <= cut) begin
                if (b) rq_b.push_back(r);
                else   rq_a.push_back(r);
            end
        end
        if (t + 1 <= cut) push_ctl(b, t + 1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, addr);
        if (!b) begin
            for (int k = 0; k < n; k++)
                for (int j = 0; j < ac; j++)
                    if (t + 2 + ac * k + j <= cut)
                        push_ctl(b, t + 2 + ac * k + j, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, (addr + k) & 'h1FFF);
        end
        if (endc <= cut)     push_ctl(b, endc, 1'b1, 1'b1, 1'b0, 1'b1, b, (addr + n - 1) & 'h1FFF);
        if (endc + 1 <= cut) push_ctl(b, endc + 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input bit b);
        int k;
        k = 0;
        while ((b ? b_req_ready : a_req_ready) !== 1'b1) begin
            step();
            k++;
            if (k > 400) begin
                $display("FAIL ready_timeout dut=%0d at cycle %0d: req_ready stuck low, expected high", b, cyc);
                $fatal(1);
            end
        end
    endtask

    task automatic do_req(input bit b, input int addr, input int cnt);
        int t;
        wait_ready(b);
        t = cyc;
        push_txn(b, t, addr, cnt, b ? 1 : 2, 1 << 30);
        if (b) begin
            b_req_valid = 1'b1; b_req_addr = AW'(addr); b_req_count = 8'(cnt);
        end else begin
            a_req_valid = 1'b1; a_req_addr = AW'(addr); a_req_count = 8'(cnt);
        end
        step();
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
    endtask

    initial begin
        int t;
        int t2;
        int k;
        reset = 1'b1;
        a_req_valid = 1'b0; a_req_addr = '0; a_req_count = '0;
        b_req_valid = 1'b0; b_req_addr = '0; b_req_count = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        push_ctl(1'b0, cyc, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0);
        push_ctl(1'b1, cyc, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0);

        // Single byte, 4-byte burst, address wrap.
        do_req(1'b0, 'h0123, 0);
        do_req(1'b0, 'h0010, 3);
        do_req(1'b0, 'h1FFE, 3);

        // Request held high across two transactions: exactly two accepts.
        wait_ready(1'b0);
        t  = cyc;
        t2 = t + 2 + 2 * 2 + 1;
        push_txn(1'b0, t,  'h0040, 1, 2, 1 << 30);
        push_txn(1'b0, t2, 'h0040, 1, 2, 1 << 30);
        a_req_valid = 1'b1; a_req_addr = AW'('h0040); a_req_count = 8'd1;
        while (cyc <= t2) step();
        a_req_valid = 1'b0;

        // Reset during the access window of byte 2 of an 8-byte burst.
        wait_ready(1'b0);
        t = cyc;
        push_txn(1'b0, t, 'h0080, 7, 2, t + 6);
        push_ctl(1'b0, t + 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0);
        a_req_valid = 1'b1; a_req_addr = AW'('h0080); a_req_count = 8'd7;
        step();
        a_req_valid = 1'b0;
        while (cyc < t + 6) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        do_req(1'b0, 'h0200, 1);

        // Single-cycle access: 256 back-to-back bytes.
        do_req(1'b1, 'h0000, 255);

        wait_ready(1'b0);
        wait_ready(1'b1);
        repeat (3) step();
        fin_req = 1'b1;
        k = 0;
        while (!fin_done && k < 10) begin
            step();
            k++;
        end
        if (!fin_done) $display("FAIL monitor_final: final scoreboard check did not run");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
